// File: rtl/l1_d_pkg.sv
// Shared types, widths and address-slicing helpers for the L1 data cache controller.
package l1_d_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INDEX_W  = 5;
    localparam int unsigned OFFSET_W = 6;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned NUM_SETS = 1 << INDEX_W;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [INDEX_W-1:0]  index_t;
    typedef logic [OFFSET_W-1:0] offset_t;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITE_BACK,
        ALLOCATE
    } state_e;

    function automatic tag_t addr_tag(input addr_t a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic index_t addr_index(input addr_t a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic offset_t addr_offset(input addr_t a);
        return a[OFFSET_W-1:0];
    endfunction

    function automatic addr_t line_addr(input tag_t t, input index_t i);
        return {t, i, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/l1_d_cache_ctrl_if.sv
// Core-side and L2-side signal bundle of the L1 data cache controller.
interface l1_d_cache_ctrl_if;
    import l1_d_pkg::*;

    logic    req_C_L1;
    logic    rw_C_L1;
    addr_t   addr_C_L1;
    logic    ready_L1_C;
    logic    stall_L1_C;
    index_t  index_C_L1;
    offset_t offset;
    logic    way;
    logic    update;
    logic    refill;
    logic    read_req_L1_L2;
    logic    write_req_L1_L2;
    addr_t   addr_L1_L2;
    logic    ready_L2_L1;

    // master: core and L2 environment; slave: the controller
    modport master (
        output req_C_L1, rw_C_L1, addr_C_L1, ready_L2_L1,
        input  ready_L1_C, stall_L1_C, index_C_L1, offset, way, update, refill,
               read_req_L1_L2, write_req_L1_L2, addr_L1_L2
    );

    modport slave (
        input  req_C_L1, rw_C_L1, addr_C_L1, ready_L2_L1,
        output ready_L1_C, stall_L1_C, index_C_L1, offset, way, update, refill,
               read_req_L1_L2, write_req_L1_L2, addr_L1_L2
    );

endinterface

// File: rtl/l1_d_tag_array.sv
// Tag/valid/dirty storage for 32 sets x 2 ways plus one LRU (victim) bit per set.
module l1_d_tag_array
    import l1_d_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  index_t index_i,
    input  tag_t   tag_i,
    output logic   hit_o,
    output logic   hit_way_o,
    output logic   victim_way_o,
    output logic   victim_wb_o,
    input  logic   tag_rd_way_i,
    output tag_t   tag_rd_o,
    input  logic   wr_way_i,
    input  logic   refill_we_i,
    input  logic   set_dirty_i,
    input  logic   clr_dirty_i,
    input  logic   lru_we_i,
    input  logic   lru_i
);

    tag_t                tag_q   [NUM_SETS][2];
    logic [1:0]          valid_q [NUM_SETS];
    logic [1:0]          dirty_q [NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    logic [1:0] match;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (refill_we_i) begin
                valid_q[index_i][wr_way_i] <= 1'b1;
                dirty_q[index_i][wr_way_i] <= 1'b0;
            end else if (set_dirty_i) begin
                dirty_q[index_i][wr_way_i] <= 1'b1;
            end else if (clr_dirty_i) begin
                dirty_q[index_i][wr_way_i] <= 1'b0;
            end
            if (lru_we_i) begin
                lru_q[index_i] <= lru_i;
            end
        end
    end

    // Tags need no reset: they are qualified by valid everywhere they are used.
    always_ff @(posedge clk) begin
        if (refill_we_i) begin
            tag_q[index_i][wr_way_i] <= tag_i;
        end
    end

    always_comb begin
        match[0]  = valid_q[index_i][0] && (tag_q[index_i][0] == tag_i);
        match[1]  = valid_q[index_i][1] && (tag_q[index_i][1] == tag_i);
        hit_o     = |match;
        hit_way_o = match[1];

        if (!valid_q[index_i][0]) begin
            victim_way_o = 1'b0;
        end else if (!valid_q[index_i][1]) begin
            victim_way_o = 1'b1;
        end else begin
            victim_way_o = lru_q[index_i];
        end
        victim_wb_o = valid_q[index_i][victim_way_o] && dirty_q[index_i][victim_way_o];
        tag_rd_o    = tag_q[index_i][tag_rd_way_i];
    end

endmodule

// File: rtl/l1_d_cache_ctrl.sv
// L1 data cache sequencer: hit/miss resolution, data-array steering and L2 write-back/refill.
module l1_d_cache_ctrl
    import l1_d_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    l1_d_cache_ctrl_if.slave  bus
);

    state_e state_q, state_d;
    addr_t  addr_q, addr_d;
    logic   rw_q, rw_d;
    logic   victim_q, victim_d;

    logic   hit, hit_way, victim_way, victim_wb;
    tag_t   victim_tag;
    logic   wr_way, refill_we, set_dirty, clr_dirty, lru_we;
    logic   ready;

    l1_d_tag_array u_tags (
        .clk          (clk),
        .rst          (rst),
        .index_i      (addr_index(addr_q)),
        .tag_i        (addr_tag(addr_q)),
        .hit_o        (hit),
        .hit_way_o    (hit_way),
        .victim_way_o (victim_way),
        .victim_wb_o  (victim_wb),
        .tag_rd_way_i (victim_q),
        .tag_rd_o     (victim_tag),
        .wr_way_i     (wr_way),
        .refill_we_i  (refill_we),
        .set_dirty_i  (set_dirty),
        .clr_dirty_i  (clr_dirty),
        .lru_we_i     (lru_we),
        .lru_i        (~hit_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            victim_q <= victim_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        addr_d              = addr_q;
        rw_d                = rw_q;
        victim_d            = victim_q;
        wr_way              = victim_q;
        refill_we           = 1'b0;
        set_dirty           = 1'b0;
        clr_dirty           = 1'b0;
        lru_we              = 1'b0;
        ready               = 1'b0;
        bus.update          = 1'b0;
        bus.refill          = 1'b0;
        bus.read_req_L1_L2  = 1'b0;
        bus.write_req_L1_L2 = 1'b0;
        bus.addr_L1_L2      = '0;
        bus.way             = 1'b0;
        bus.index_C_L1      = addr_index(addr_q);
        bus.offset          = addr_offset(addr_q);

        unique case (state_q)
            IDLE: begin
                bus.index_C_L1 = addr_index(bus.addr_C_L1);
                bus.offset     = addr_offset(bus.addr_C_L1);
                if (bus.req_C_L1) begin
                    addr_d  = bus.addr_C_L1;
                    rw_d    = bus.rw_C_L1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit) begin
                    ready      = 1'b1;
                    bus.way    = hit_way;
                    wr_way     = hit_way;
                    lru_we     = 1'b1;
                    bus.update = rw_q;
                    set_dirty  = rw_q;
                    state_d    = IDLE;
                end else begin
                    bus.way  = victim_way;
                    victim_d = victim_way;
                    state_d  = victim_wb ? WRITE_BACK : ALLOCATE;
                end
            end
            WRITE_BACK: begin
                bus.write_req_L1_L2 = 1'b1;
                bus.addr_L1_L2      = line_addr(victim_tag, addr_index(addr_q));
                bus.way             = victim_q;
                if (bus.ready_L2_L1) begin
                    clr_dirty = 1'b1;
                    state_d   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.read_req_L1_L2 = 1'b1;
                bus.addr_L1_L2     = line_addr(addr_tag(addr_q), addr_index(addr_q));
                bus.way            = victim_q;
                // Refill strobes in the L2-ready cycle so the array captures the line on this edge.
                if (bus.ready_L2_L1) begin
                    bus.refill = 1'b1;
                    refill_we  = 1'b1;
                    state_d    = COMPARE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ready_L1_C = ready;
    assign bus.stall_L1_C = (state_q != IDLE) && !ready;

endmodule

// File: tb/tb_l1_d_cache_ctrl.sv
// Directed plus randomized checks of l1_d_cache_ctrl against a set/way/recency cache model.
module tb_l1_d_cache_ctrl;

    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_err;

    l1_d_cache_ctrl_if bus ();

    l1_d_cache_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per set two lines and the most recently used way.
    logic [20:0] m_tag   [32][2];
    bit          m_valid [32][2];
    bit          m_dirty [32][2];
    bit          m_mru   [32];

    int unsigned last_n;
    int unsigned last_rd_cnt;
    logic [31:0] last_wb_addr;
    logic [31:0] last_rd_addr;
    logic        last_refill_way;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 32; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
            m_mru[s] = 1'b1;
        end
    endtask

    task automatic model_access(input bit rw, input logic [31:0] a, output bit hit, output bit w,
                                output bit wb, output logic [31:0] wbaddr, output logic [31:0] rdaddr);
        logic [4:0]  s;
        logic [20:0] t;
        s      = a[10:6];
        t      = a[31:11];
        hit    = 1'b0;
        w      = 1'b0;
        wb     = 1'b0;
        wbaddr = '0;
        rdaddr = {t, s, 6'b0};
        for (int i = 0; i < 2; i++) begin
            if (m_valid[s][i] && m_tag[s][i] == t) begin
                hit = 1'b1;
                w   = (i == 1);
            end
        end
        if (!hit) begin
            if (!m_valid[s][0])      w = 1'b0;
            else if (!m_valid[s][1]) w = 1'b1;
            else                     w = ~m_mru[s];
            wb     = m_valid[s][w] && m_dirty[s][w];
            wbaddr = {m_tag[s][w], s, 6'b0};
            m_valid[s][w] = 1'b1;
            m_tag[s][w]   = t;
            m_dirty[s][w] = 1'b0;
        end
        if (rw) m_dirty[s][w] = 1'b1;
        m_mru[s] = w;
    endtask

    // One core access with an L2 responder of the given latencies; every cycle is checked.
    task automatic run_access(input bit rw, input logic [31:0] a, input int unsigned lwb,
                              input int unsigned lrd, input bit scramble);
        bit          hit, w, wb;
        logic [31:0] wbaddr, rdaddr;
        int unsigned exp_n, c, wb_cnt, rd_cnt;
        model_access(rw, a, hit, w, wb, wbaddr, rdaddr);
        exp_n  = hit ? 1 : 2 + lrd + (wb ? lwb : 0);
        c      = 0;
        wb_cnt = 0;
        rd_cnt = 0;
        last_n = 0;
        @(negedge clk);
        bus.req_C_L1  = 1'b1;
        bus.rw_C_L1   = rw;
        bus.addr_C_L1 = a;
        while (c < exp_n) begin
            @(negedge clk);
            c++;
            bus.ready_L2_L1 = 1'b0;
            if (scramble && c == 2) begin
                bus.addr_C_L1 = $urandom;
                bus.rw_C_L1   = ~rw;
            end
            #1;
            chk("ready", bus.ready_L1_C, c == exp_n);
            chk("stall", bus.stall_L1_C, c != exp_n);
            chk("update", bus.update, (c == exp_n) && rw);
            chk("index", bus.index_C_L1, a[10:6]);
            chk("offset", bus.offset, a[5:0]);
            chk("one_l2_req", bus.read_req_L1_L2 & bus.write_req_L1_L2, 0);
            if (bus.ready_L1_C && last_n == 0) last_n = c;
            if (c == exp_n) chk("hit_way", bus.way, w);
            if (bus.write_req_L1_L2) begin
                wb_cnt++;
                last_wb_addr = bus.addr_L1_L2;
                chk("wb_addr", bus.addr_L1_L2, wbaddr);
                chk("wb_way", bus.way, w);
                if (wb_cnt == lwb) begin
                    bus.ready_L2_L1 = 1'b1;
                    #1;
                    chk("wb_no_refill", bus.refill, 0);
                end
            end else if (bus.read_req_L1_L2) begin
                rd_cnt++;
                last_rd_addr = bus.addr_L1_L2;
                chk("rd_addr", bus.addr_L1_L2, rdaddr);
                chk("rd_way", bus.way, w);
                if (rd_cnt == lrd) begin
                    bus.ready_L2_L1 = 1'b1;
                    #1;
                    chk("refill", bus.refill, 1);
                    chk("refill_no_update", bus.update, 0);
                    last_refill_way = bus.way;
                end
            end
        end
        bus.req_C_L1  = 1'b0;
        bus.addr_C_L1 = a;
        bus.rw_C_L1   = rw;
        last_rd_cnt   = rd_cnt;
        chk("wb_cycles", wb_cnt, wb ? lwb : 0);
        chk("rd_cycles", rd_cnt, hit ? 0 : lrd);
        @(negedge clk);
        bus.ready_L2_L1 = 1'b0;
        #1;
        chk("idle_stall", bus.stall_L1_C, 0);
        chk("idle_ready", bus.ready_L1_C, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        last_wb_addr = '0;
        last_rd_addr = '0;
        last_refill_way = 1'b0;
        model_reset();
        rst = 1'b1;
        bus.req_C_L1    = 1'b0;
        bus.rw_C_L1     = 1'b0;
        bus.addr_C_L1   = 32'h0000_1044;
        bus.ready_L2_L1 = 1'b0;
        #2;
        chk("rst_ready", bus.ready_L1_C, 0);
        chk("rst_stall", bus.stall_L1_C, 0);
        chk("rst_l2_reqs", {bus.read_req_L1_L2, bus.write_req_L1_L2}, 0);
        chk("rst_strobes", {bus.update, bus.refill, bus.way}, 0);
        chk("rst_addr_l2", bus.addr_L1_L2, 0);
        chk("idle_index", bus.index_C_L1, 1);
        chk("idle_offset", bus.offset, 4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cold clean miss, L2 ready three cycles after read_req rises.
        run_access(1'b0, 32'h0000_1040, 1, 4, 1'b0);
        chk("cold_latency", last_n, 6);
        chk("cold_rd_addr", last_rd_addr, 32'h0000_1040);
        chk("cold_refill_way", last_refill_way, 0);

        // Store hit to the resident line.
        run_access(1'b1, 32'h0000_1044, 1, 1, 1'b0);
        chk("store_latency", last_n, 1);

        // Fill way 1, hit it, then evict dirty way 0.
        run_access(1'b0, 32'h0000_2040, 1, 2, 1'b0);
        chk("fill_w1_way", last_refill_way, 1);
        run_access(1'b0, 32'h0000_2040, 1, 1, 1'b0);
        chk("w1_hit_latency", last_n, 1);
        run_access(1'b0, 32'h0000_3040, 3, 2, 1'b0);
        chk("evict_wb_addr", last_wb_addr, 32'h0000_1040);
        chk("evict_rd_addr", last_rd_addr, 32'h0000_3040);
        chk("evict_refill_way", last_refill_way, 0);

        // Spurious L2 ready while idle.
        @(negedge clk);
        bus.ready_L2_L1 = 1'b1;
        #1;
        chk("spur_refill", bus.refill, 0);
        chk("spur_l2_reqs", {bus.read_req_L1_L2, bus.write_req_L1_L2}, 0);
        @(negedge clk);
        bus.ready_L2_L1 = 1'b0;
        #1;
        chk("spur_stall", bus.stall_L1_C, 0);
        chk("spur_ready", bus.ready_L1_C, 0);

        // Core inputs change mid-miss; the latched address must complete.
        run_access(1'b0, 32'h0000_4040, 2, 3, 1'b1);
        chk("held_rd_addr", last_rd_addr, 32'h0000_4040);

        // Reset while read_req is high.
        begin
            bit seen;
            seen = 1'b0;
            @(negedge clk);
            bus.req_C_L1  = 1'b1;
            bus.rw_C_L1   = 1'b0;
            bus.addr_C_L1 = 32'h0000_5040;
            for (int i = 0; i < 8 && !seen; i++) begin
                @(negedge clk);
                #1;
                seen = bus.read_req_L1_L2;
            end
            chk("rst_saw_rdreq", seen, 1);
            rst = 1'b1;
            #1;
            chk("midrst_l2_reqs", {bus.read_req_L1_L2, bus.write_req_L1_L2}, 0);
            chk("midrst_stall", bus.stall_L1_C, 0);
            chk("midrst_strobes", {bus.update, bus.refill, bus.ready_L1_C}, 0);
            bus.req_C_L1 = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
        end
        run_access(1'b0, 32'h0000_1040, 1, 2, 1'b0);
        chk("post_rst_miss", last_rd_cnt != 0, 1);

        // Randomized traffic over a few sets and tags to exercise hits, LRU and write-backs.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] ra;
            ra = {21'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
            run_access(1'($urandom_range(0, 1)), ra, $urandom_range(1, 4), $urandom_range(1, 4),
                       ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_d_cache_ctrl.md
Name:
l1_d_cache_ctrl

Overview:
- Sequencing controller for the L1 data cache: 32 sets × 2 ways × 512-bit lines.
- Holds the tag, valid, dirty and LRU state.
- Resolves core load/store hits and misses.
- Drives the data-array control signals: index, offset, way, update, refill.
- Runs the L2 handshake for dirty write-back and line refill.
- Sits between the core interface and L2; the data array remains a separate instance steered by this block.

Parameters:
- ADDR_W, 32, core/L2 byte-address width
- INDEX_W, 5, set index width (32 sets)
- OFFSET_W, 6, byte offset within a 64-byte line
- TAG_W, ADDR_W-INDEX_W-OFFSET_W = 21, stored tag width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_C_L1  in  1  core request, held until ready_L1_C
- rw_C_L1  in  1  1 = store, 0 = load; stable while req high
- addr_C_L1  in  32  byte address; tag [31:11], index [10:6], offset [5:0]
- ready_L1_C  out  1  one-cycle completion pulse to core
- stall_L1_C  out  1  high while a request is in flight and not completing
- index_C_L1  out  5  set index to data array
- offset  out  6  byte offset to data array
- way  out  1  selected way to data array
- update  out  1  store-word strobe to data array
- refill  out  1  line-write strobe to data array
- read_req_L1_L2  out  1  line fetch request
- write_req_L1_L2  out  1  dirty line write-back request
- addr_L1_L2  out  32  line address, offset bits forced to 0
- ready_L2_L1  in  1  L2 completion for the current request

Behaviour:
- Reset values: all outputs 0; state IDLE; all valid, dirty and LRU bits cleared; latched address 0. The cache top level ties the data array reset to ~rst.
- States are IDLE, COMPARE, WRITE_BACK and ALLOCATE.
- IDLE:
  - If req_C_L1 is high, latch addr_C_L1 and rw_C_L1, then go to COMPARE.
  - ready_L2_L1 is ignored.
- COMPARE (single cycle):
  - Both ways are compared against the latched tag; hit = valid & tag match.
  - Load hit: ready_L1_C=1, way=hit way. Data is read combinationally from the data array in this cycle. Go to IDLE.
  - Store hit: update=1, ready_L1_C=1, dirty[hit way]<=1. Go to IDLE.
  - Any hit: LRU[index] <= ~hit way (the other way becomes the victim).
  - Miss, victim choice: invalid way0 first, else invalid way1, else LRU[index].
  - Miss, next state: if the victim is valid & dirty, go to WRITE_BACK; else go to ALLOCATE.
- WRITE_BACK:
  - Drive write_req_L1_L2=1, addr_L1_L2={victim tag, index, 6'b0}, way=victim. The array presents the victim line on its write-data output.
  - Hold until ready_L2_L1=1. On that edge: dirty[victim]<=0, go to ALLOCATE.
- ALLOCATE:
  - Drive read_req_L1_L2=1, addr_L1_L2={tag, index, 6'b0}, way=victim.
  - When ready_L2_L1=1: refill=1 combinationally in the same cycle, so the array captures the L2 line on that edge.
  - On that edge also: tag[victim]<=tag, valid<=1, dirty<=0. Go to COMPARE; the re-lookup hits and completes the original load or store.
- Latency:
  - Hit: ready 1 cycle after req is sampled in IDLE.
  - Clean miss: 1 + L2 latency + 1 cycles.
  - Dirty miss: adds the write-back L2 latency.
- stall_L1_C = (state != IDLE) & ~ready_L1_C.
- index_C_L1 and offset come from the latched address in every non-IDLE state, and from addr_C_L1 in IDLE.
- The core must hold req, rw and addr until ready; changes mid-flight are ignored.
- update and refill are never asserted together. ready_L1_C never coincides with an L2 request.
- Reset asserted mid-operation: immediate return to IDLE; L2 requests drop asynchronously; all lines become invalid.
- At most one L2 request is outstanding at any time.

Decomposition:
- Package l1_d_pkg: state enum (IDLE, COMPARE, WRITE_BACK, ALLOCATE); INDEX_W, OFFSET_W and TAG_W constants; address-slice helper functions.
- Sub-module l1_d_tag_array: 32×2 tag/valid/dirty storage plus 32 LRU bits.
  - Combinational hit and victim outputs.
  - Synchronous write ports for refill, set-dirty, clear-dirty and LRU.
  - Asynchronous clear on rst.

Test Plan:
- Cold load, clean miss:
  - Stimulus: after reset, load 0x0000_1040 (index 1, tag 2).
  - Required: read_req=1 with addr_L1_L2=0x0000_1040. With ready_L2_L1 3 cycles later, refill=1 for index 1, way 0. COMPARE then hits and ready_L1_C pulses 6 cycles after the request was sampled.
- Store hit:
  - Stimulus: store to 0x0000_1044.
  - Required: the cycle after req, update=1, way=0, offset=4, ready_L1_C=1. dirty[1][0]=1. No L2 request.
- LRU eviction with dirty write-back:
  - Stimulus: load 0x0000_2040 (fills way 1), then load 0x0000_3040.
  - Required: victim is way 0. write_req with addr 0x0000_1040; after ready_L2_L1, read_req with addr 0x0000_3040, then refill to way 0.
- Reset during ALLOCATE:
  - Stimulus: assert rst while read_req is high.
  - Required: read_req, stall and all strobes are 0 immediately. A following load to 0x0000_1040 misses.
- Spurious and held inputs:
  - Stimulus: pulse ready_L2_L1 in IDLE, and change addr_C_L1 mid-miss.
  - Required: no state change; the miss completes for the originally latched address.
- Way-1 hit:
  - Stimulus: after 0x2040 is resident, load 0x0000_2040.
  - Required: way=1, ready in 1 cycle, LRU[1]=0.
